// File: rtl/timebase_pkg.sv
// ---------------------------------------------------------------------------
// timebase_pkg
// Shared types and constants for the acquisition timebase controller.
//   tb_state_t : controller state encoding (IDLE=0, ARMED=1, CAPTURE=2, HOLD=3)
//   RATE_W     : width of the rate selector
//   DIV_W      : width of the sample-rate divider (largest ratio is 200)
//   DIV_TABLE  : 1-2-5 divide ratios indexed by rate selector
//   div_lookup : rate selector -> divide ratio
// ---------------------------------------------------------------------------
package timebase_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } tb_state_t;

    localparam int RATE_W = 3;
    localparam int DIV_W  = 8;

    localparam logic [DIV_W-1:0] DIV_TABLE [0:(1<<RATE_W)-1] = '{
        8'd1, 8'd2, 8'd5, 8'd10, 8'd20, 8'd50, 8'd100, 8'd200
    };

    function automatic logic [DIV_W-1:0] div_lookup(input logic [RATE_W-1:0] sel);
        return DIV_TABLE[sel];
    endfunction

endpackage

// File: rtl/timebase_div.sv
// ---------------------------------------------------------------------------
// timebase_div
// Clearable modulo counter producing the sample strobe.
//   clk_in : system clock
//   rst    : asynchronous active-high reset
//   en     : count enable
//   clr    : synchronous clear to 0 (wins over en)
//   div    : modulus; count runs 0..div-1
//   tick   : high while enabled and the count sits at div-1
// ---------------------------------------------------------------------------
module timebase_div
    import timebase_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] cnt;

    // Combinational from registers only, so the strobe lands on the cycle
    // the count equals div-1 rather than one cycle later.
    assign tick = en && (cnt == div - ONE);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + ONE;
        end
    end

endmodule

// File: rtl/timebase_ctrl.sv
// ---------------------------------------------------------------------------
// timebase_ctrl
// Acquisition timebase: divides the clock into one-cycle sample strobes at a
// 1-2-5 rate and sequences arm -> trigger -> fixed-length capture -> hand-off.
//
// Optional feature macro: TIMEBASE_AUTOTRIG_EN
//   defined   : ARMED self-triggers after AUTO_TIMEOUT cycles without trig
//   undefined : ARMED waits indefinitely, auto_trig tied 0
//
// Ports
//   clk_in      in   system clock
//   rst         in   asynchronous active-high reset
//   rate_sel    in   index into DIV_TABLE, latched on entry to ARMED
//   arm         in   one-cycle request to start acquisition
//   single      in   1 = stop after one frame, 0 = re-arm after ack
//   trig        in   one-cycle trigger event
//   stop        in   abort to IDLE from any state (highest priority)
//   frame_ack   in   display side has consumed the frame
//   sample_en   out  one-cycle sample strobe (CAPTURE only)
//   sample_idx  out  write index of the current strobe
//   done        out  one-cycle pulse on entry to HOLD
//   frame_ready out  frame complete and awaiting ack
//   busy        out  high in ARMED or CAPTURE
//   state_o     out  current state encoding
//   auto_trig   out  last frame was auto-triggered
// ---------------------------------------------------------------------------
module timebase_ctrl
    import timebase_pkg::*;
#(
    parameter int FREQ_IN      = 100_000_000,
    parameter int REC_LEN      = 640,
    parameter int AUTO_TIMEOUT = 10_000_000
) (
    input  logic                       clk_in,
    input  logic                       rst,
    input  logic [RATE_W-1:0]          rate_sel,
    input  logic                       arm,
    input  logic                       single,
    input  logic                       trig,
    input  logic                       stop,
    input  logic                       frame_ack,
    output logic                       sample_en,
    output logic [$clog2(REC_LEN)-1:0] sample_idx,
    output logic                       done,
    output logic                       frame_ready,
    output logic                       busy,
    output logic [1:0]                 state_o,
    output logic                       auto_trig
);

    localparam int IDX_W = $clog2(REC_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(REC_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    tb_state_t        state;
    logic [DIV_W-1:0] div_q;
    logic [IDX_W-1:0] idx;
    logic             go;
    logic             start_capture;
    logic             enter_armed;
    logic             tick;

    // Transition qualifiers shared by the FSM and the auto-trigger logic.
    assign start_capture = !stop && (state == ARMED) && go;
    assign enter_armed   = !stop && (((state == IDLE) && arm) ||
                                     ((state == HOLD) && frame_ack && !single));

`ifdef TIMEBASE_AUTOTRIG_EN
    // AUTO_TIMEOUT must be >= 2 so the counter has at least one bit.
    localparam int TMO_W = $clog2(AUTO_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(AUTO_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    logic [TMO_W-1:0] tmo;
    logic             auto_fire;
    logic             auto_q;

    // A real trig on the timeout cycle takes precedence and counts as real.
    assign auto_fire = (state == ARMED) && !trig && (tmo == TMO_LAST);
    assign go        = trig || auto_fire;
    assign auto_trig = auto_q;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            tmo    <= '0;
            auto_q <= 1'b0;
        end else begin
            // Held at 0 outside ARMED, so every ARMED entry starts from 0.
            if (state != ARMED || stop) begin
                tmo <= '0;
            end else begin
                tmo <= tmo + TMO_ONE;
            end
            if (enter_armed) begin
                auto_q <= 1'b0;
            end else if (start_capture) begin
                auto_q <= auto_fire;
            end
        end
    end
`else
    assign go        = trig;
    assign auto_trig = 1'b0;
`endif

    timebase_div u_div (
        .clk_in (clk_in),
        .rst    (rst),
        .en     ((state == CAPTURE) && !stop),
        .clr    (start_capture || stop),
        .div    (div_q),
        .tick   (tick)
    );

    assign sample_en  = tick;
    assign sample_idx = idx;
    assign state_o    = state;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            div_q       <= DIV_TABLE[0];
            idx         <= '0;
            done        <= 1'b0;
            frame_ready <= 1'b0;
            busy        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state       <= IDLE;
                idx         <= '0;
                frame_ready <= 1'b0;
                busy        <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        // A same-cycle trig is dropped; only the arm lands.
                        if (arm) begin
                            state <= ARMED;
                            busy  <= 1'b1;
                            div_q <= div_lookup(rate_sel);
                        end
                    end
                    ARMED: begin
                        if (go) begin
                            state <= CAPTURE;
                            idx   <= '0;
                        end
                    end
                    CAPTURE: begin
                        if (tick) begin
                            // Index stays on the last sample while in HOLD.
                            if (idx == IDX_LAST) begin
                                state       <= HOLD;
                                done        <= 1'b1;
                                frame_ready <= 1'b1;
                                busy        <= 1'b0;
                            end else begin
                                idx <= idx + IDX_ONE;
                            end
                        end
                    end
                    HOLD: begin
                        if (frame_ack) begin
                            frame_ready <= 1'b0;
                            if (single) begin
                                state <= IDLE;
                            end else begin
                                state <= ARMED;
                                busy  <= 1'b1;
                                div_q <= div_lookup(rate_sel);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_timebase_ctrl.sv
// ---------------------------------------------------------------------------
// tb_timebase_ctrl
// Directed bench for timebase_ctrl (REC_LEN=640, AUTO_TIMEOUT=50).
// Inputs change and outputs are observed on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_timebase_ctrl;

    localparam int REC_LEN = 640;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] rate_sel = 3'd0;
    logic       arm = 1'b0;
    logic       single = 1'b1;
    logic       trig = 1'b0;
    logic       stop = 1'b0;
    logic       frame_ack = 1'b0;
    logic       sample_en;
    logic [9:0] sample_idx;
    logic       done;
    logic       frame_ready;
    logic       busy;
    logic [1:0] state_o;
    logic       auto_trig;

    int n_cmp = 0;
    int n_err = 0;

    timebase_ctrl #(
        .FREQ_IN      (100_000_000),
        .REC_LEN      (REC_LEN),
        .AUTO_TIMEOUT (50)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .rate_sel    (rate_sel),
        .arm         (arm),
        .single      (single),
        .trig        (trig),
        .stop        (stop),
        .frame_ack   (frame_ack),
        .sample_en   (sample_en),
        .sample_idx  (sample_idx),
        .done        (done),
        .frame_ready (frame_ready),
        .busy        (busy),
        .state_o     (state_o),
        .auto_trig   (auto_trig)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        @(negedge clk_in);
        arm = 1'b0;
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        @(negedge clk_in);
        trig = 1'b0;
    endtask

    task automatic pulse_ack();
        frame_ack = 1'b1;
        @(negedge clk_in);
        frame_ack = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk_in);
        stop = 1'b0;
    endtask

    // Called in the first cycle after the trig edge. Strobe k (0-based)
    // is expected on cycle (k+1)*div, index (c-1)/div on cycle c.
    task automatic run_frame(input int div, input string tag);
        int bad = 0;
        int strobes = 0;
        for (int c = 1; c <= REC_LEN * div; c++) begin
            if (sample_en !== ((c % div) == 0)) bad++;
            if (sample_idx !== 10'((c - 1) / div)) bad++;
            if (done !== 1'b0) bad++;
            if (sample_en === 1'b1) strobes++;
            @(negedge clk_in);
        end
        chk({tag, "_pattern_errs"}, bad, 0);
        chk({tag, "_strobes"}, strobes, REC_LEN);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_frame_ready"}, frame_ready, 1);
        chk({tag, "_state_hold"}, state_o, 3);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int cnt;

        // Reset state
        repeat (2) @(negedge clk_in);
        chk("rst_state", state_o, 0);
        chk("rst_sample_en", sample_en, 0);
        chk("rst_idx", sample_idx, 0);
        chk("rst_done", done, 0);
        chk("rst_frame_ready", frame_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_auto_trig", auto_trig, 0);
        rst = 1'b0;
        @(negedge clk_in);

        // Frame at div 1, single shot; frame_ack in ARMED is ignored
        rate_sel = 3'd0;
        single   = 1'b1;
        pulse_arm();
        chk("arm_state", state_o, 1);
        chk("arm_busy", busy, 1);
        pulse_ack();
        chk("ack_in_armed_state", state_o, 1);
        pulse_trig();
        run_frame(1, "div1");
        chk("div1_auto_trig", auto_trig, 0);
        @(negedge clk_in);
        chk("div1_done_one_cycle", done, 0);
        chk("div1_ready_held", frame_ready, 1);
        pulse_ack();
        chk("div1_ack_idle", state_o, 0);
        chk("div1_ack_ready_clr", frame_ready, 0);

        // Frame at div 5, single shot
        rate_sel = 3'd2;
        pulse_arm();
        pulse_trig();
        run_frame(5, "div5");
        pulse_ack();
        chk("div5_ack_idle", state_o, 0);
        chk("div5_ack_busy", busy, 0);

        // Continuous mode: rate changed mid-capture applies to next frame
        rate_sel = 3'd0;
        single   = 1'b0;
        pulse_arm();
        pulse_trig();
        rate_sel = 3'd3;
        run_frame(1, "cont1");
        pulse_ack();
        chk("cont_rearm_state", state_o, 1);
        chk("cont_rearm_busy", busy, 1);
        chk("cont_rearm_ready", frame_ready, 0);
        pulse_trig();
        run_frame(10, "cont10");
        single = 1'b1;
        pulse_ack();
        chk("cont_end_idle", state_o, 0);

        // Stop during capture at sample index 100
        rate_sel = 3'd0;
        pulse_arm();
        pulse_trig();
        repeat (100) @(negedge clk_in);
        chk("stop_pre_idx", sample_idx, 100);
        chk("stop_pre_strobe", sample_en, 1);
        pulse_stop();
        chk("stop_state", state_o, 0);
        chk("stop_busy", busy, 0);
        chk("stop_idx", sample_idx, 0);
        chk("stop_done", done, 0);
        chk("stop_sample_en", sample_en, 0);
        pulse_trig();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (sample_en === 1'b1 || done === 1'b1) cnt++;
            @(negedge clk_in);
        end
        chk("stop_trig_no_strobe", cnt, 0);
        chk("stop_trig_state", state_o, 0);

        // Same-cycle arm and trig in IDLE
        arm  = 1'b1;
        trig = 1'b1;
        @(negedge clk_in);
        arm  = 1'b0;
        trig = 1'b0;
        chk("armtrig_state", state_o, 1);
        chk("armtrig_sample_en", sample_en, 0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (sample_en === 1'b1) cnt++;
            @(negedge clk_in);
        end
        chk("armtrig_no_strobe", cnt, 0);
        chk("armtrig_still_armed", state_o, 1);
        pulse_stop();
        chk("armtrig_stop_idle", state_o, 0);

        // Auto-trigger timeout
        pulse_arm();
`ifdef TIMEBASE_AUTOTRIG_EN
        repeat (49) @(negedge clk_in);
        chk("auto_armed_at_50", state_o, 1);
        @(negedge clk_in);
        chk("auto_capture", state_o, 2);
        chk("auto_trig_flag", auto_trig, 1);
`else
        repeat (1000) @(negedge clk_in);
        chk("noauto_still_armed", state_o, 1);
        chk("noauto_flag", auto_trig, 0);
`endif
        pulse_stop();
        chk("final_idle", state_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
